segment_frame_decoder: RTL and testbench
========================================

SEGMENT_FRAME_DECODER -- requirements
Module: segment_frame_decoder

Interface
REQ-001 Parameter DIGITS, default 6: number of multiplexed seven-segment digits.
REQ-002 Parameter STABLE_CYCLES, default 4: consecutive identical samples required to accept a digit (range 1..15).
REQ-003 Port clock input 1: single clock; all logic on its rising edge.
REQ-004 Port reset input 1: synchronous, active-high reset.
REQ-005 Port seg_in input 8: bit7 = decimal point, bits6:0 = segments g..a; all bits active-low.
REQ-006 Port digit_sel input DIGITS: one-hot digit strobe; bit i selects digit i, with digit 0 least significant.
REQ-007 Port seg_valid input 1: qualifies seg_in/digit_sel this cycle.
REQ-008 Port hex_out output 4*DIGITS: last published frame, nibble i = digit i.
REQ-009 Port dp_out output DIGITS: last published decimal points, active-high.
REQ-010 Port frame_valid output 1: one-cycle pulse when hex_out/dp_out update.
REQ-011 Port pattern_error output DIGITS: sticky per-digit flag for an unrecognised segment pattern.
REQ-012 Port sel_error output 1: one-cycle pulse on seg_valid with non-one-hot digit_sel.

Function
REQ-013 Decode table (seg_in[6:0] hex -> nibble): 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->b, 46->C, 21->d, 06->E, 0E->F; any other value is invalid.
REQ-014 Stability filter: on seg_valid with one-hot digit_sel, the count becomes 1 if {seg_in, digit_sel} differs from the previous accepted sample, else it increments, saturating at STABLE_CYCLES.
REQ-015 Commit: in the cycle the count first reaches STABLE_CYCLES, the decoded nibble and dp go to shadow slot i and captured[i] is set; a held stable value does not re-commit.
REQ-016 Invalid pattern at commit: set pattern_error[i] and leave shadow slot i and captured[i] unchanged.
REQ-017 seg_valid low: filter count and previous sample hold; no commit.
REQ-018 seg_valid high with zero or multiple digit_sel bits: sample ignored, count cleared to 0, sel_error pulses the next cycle.
REQ-019 FSM states: IDLE (captured all zero), FILLING (some captured), PUBLISH.
REQ-020 IDLE->FILLING on any commit; FILLING->PUBLISH in the cycle after captured becomes all ones; PUBLISH->IDLE unconditionally after one cycle.
REQ-021 In PUBLISH: copy shadow to hex_out/dp_out, pulse frame_valid, and clear captured; a commit in the same cycle lands in the new frame, and the FSM goes to FILLING instead of IDLE.
REQ-022 Latency: frame_valid is asserted 2 cycles after the clock edge that commits the last missing digit.
REQ-023 Re-commit of an already-captured digit before PUBLISH overwrites its shadow slot (last value wins).
REQ-024 pattern_error bits clear only on reset or when the same digit later commits a valid pattern.

Reset
REQ-025 Reset forces hex_out=0, dp_out=0, frame_valid=0, sel_error=0, pattern_error=0, captured=0, count=0, state IDLE, and previous sample = all ones.
REQ-026 Reset mid-frame discards the partial shadow contents, and no frame_valid is produced for that frame.

Configuration
REQ-027 Macro SEGMENT_DECODER_DP_EN defined: seg_in[7] is decoded into dp_out and takes part in the stability compare.
REQ-028 Macro undefined: seg_in[7] is ignored everywhere, and dp_out is tied to 0.

Structure
REQ-029 A shared package holds the 16-entry segment pattern constants (shared with the encoder), the FSM state enum, and the count width constant.
REQ-030 One sub-module, segment_to_hex: combinational 7-bit -> {valid, nibble} decoder, instantiated once.

Verification
REQ-031 Reset, then DIGITS=6 and STABLE_CYCLES=4; drive digits 0..5 with 40,79,24,30,19,12, each for 4 valid cycles -> one frame_valid, hex_out=0x543210.
REQ-032 Digit 2 alternates 24/30 every cycle for 10 cycles -> no commit and no frame_valid; then hold 30 for 4 cycles -> slot 2 = 3.
REQ-033 Digit 1 held at 7F for 4 cycles -> pattern_error[1]=1, captured[1] stays 0; later 79 for 4 cycles -> pattern_error[1]=0.
REQ-034 digit_sel=000011 with seg_valid -> sel_error pulses once, count=0, no commit.
REQ-035 Assert reset after 3 digits committed -> all outputs 0, and a subsequent full frame publishes the new values only.
REQ-036 With SEGMENT_DECODER_DP_EN defined, seg_in=0x40 on digit 0 (dp bit7=0) -> dp_out[0]=1; with the macro undefined -> dp_out=0.

Source files
------------

// File: rtl/segment_frame_decoder_pkg.sv
// Shared definitions for the seven-segment frame decoder (and its encoder twin):
// segment pattern table, FSM state type and filter counter width.
package segment_frame_decoder_pkg;

  // Width of the stability counter; covers STABLE_CYCLES up to 15.
  localparam int unsigned CountWidth = 4;

  // Active-low segment patterns (bits 6:0 = g..a) for hex digits 0..F.
  localparam logic [6:0] SegPatterns [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic [1:0] {
    StIdle,
    StFilling,
    StPublish
  } state_e;

endpackage

// File: rtl/segment_to_hex.sv
// Combinational seven-segment pattern to hex nibble decoder.
// valid is low for any pattern outside the 16-entry table.
module segment_to_hex
  import segment_frame_decoder_pkg::*;
(
  input  logic [6:0] seg,
  output logic       valid,
  output logic [3:0] nibble
);

  // Table lookup against the shared pattern constants.
  always_comb begin
    valid  = 1'b0;
    nibble = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SegPatterns[i]) begin
        valid  = 1'b1;
        nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/segment_frame_decoder.sv
// Recovers a hex frame from a multiplexed seven-segment display bus.
// Each digit must be seen stable for STABLE_CYCLES qualified samples before it is
// committed to a shadow frame; once every digit is captured the frame is published.
// Optional macro SEGMENT_DECODER_DP_EN enables decimal-point decoding on seg_in[7].
module segment_frame_decoder
  import segment_frame_decoder_pkg::*;
#(
  parameter int unsigned DIGITS        = 6,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            seg_in,
  input  logic [DIGITS-1:0]     digit_sel,
  input  logic                  seg_valid,
  output logic [4*DIGITS-1:0]   hex_out,
  output logic [DIGITS-1:0]     dp_out,
  output logic                  frame_valid,
  output logic [DIGITS-1:0]     pattern_error,
  output logic                  sel_error
);

  localparam int unsigned SampleWidth = DIGITS + 8;
  localparam logic [CountWidth-1:0] StableCount = CountWidth'(STABLE_CYCLES);

  logic                   sample_dp;
  logic [SampleWidth-1:0] sample;
  logic [SampleWidth-1:0] prev_q, prev_d;
  logic [CountWidth-1:0]  count_q, count_d;
  logic                   sel_onehot;
  logic                   same_sample;
  logic                   commit;
  logic                   commit_ok;
  logic                   sel_error_q, sel_error_d;
  logic                   dec_valid;
  logic [3:0]             dec_nibble;
  state_e                 state_q, state_d;
  logic                   publish;
  logic [DIGITS-1:0]      captured_q, captured_d;
  logic [DIGITS-1:0]      perr_q, perr_d;
  logic [4*DIGITS-1:0]    shadow_q, shadow_d;
  logic [4*DIGITS-1:0]    hex_q;
  logic                   frame_valid_q;

`ifdef SEGMENT_DECODER_DP_EN
  assign sample_dp = seg_in[7];
`else
  // dp bit pinned high so it never disturbs the stability compare
  assign sample_dp = seg_in[7] | 1'b1;
`endif

  assign sel_onehot  = $onehot(digit_sel);
  assign sample      = {sample_dp, seg_in[6:0], digit_sel};
  assign same_sample = (sample == prev_q);

  segment_to_hex u_segment_to_hex (
    .seg    (seg_in[6:0]),
    .valid  (dec_valid),
    .nibble (dec_nibble)
  );

  // Stability filter: count identical qualified samples and flag the commit cycle.
  always_comb begin
    count_d     = count_q;
    prev_d      = prev_q;
    commit      = 1'b0;
    sel_error_d = 1'b0;
    if (seg_valid) begin
      if (!sel_onehot) begin
        count_d     = '0;
        sel_error_d = 1'b1;
      end else begin
        if (!same_sample) begin
          count_d = CountWidth'(1);
          prev_d  = sample;
        end else if (count_q < StableCount) begin
          count_d = count_q + CountWidth'(1);
        end
        // A value already held at saturation must not commit again.
        commit = (count_d == StableCount) && (!same_sample || (count_q != StableCount));
      end
    end
  end

  assign commit_ok = commit & dec_valid;

  // Filter state and the registered sel_error pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q     <= '0;
      prev_q      <= '1;
      sel_error_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      prev_q      <= prev_d;
      sel_error_q <= sel_error_d;
    end
  end

  // Shadow frame, capture mask and sticky pattern errors.
  always_comb begin
    // Publishing starts a fresh frame; a same-cycle commit lands in it.
    captured_d = publish ? '0 : captured_q;
    shadow_d   = shadow_q;
    perr_d     = perr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (commit && digit_sel[i]) begin
        if (dec_valid) begin
          captured_d[i]      = 1'b1;
          shadow_d[i*4 +: 4] = dec_nibble;
          perr_d[i]          = 1'b0;
        end else begin
          perr_d[i] = 1'b1;
        end
      end
    end
  end

  // FSM next state; PUBLISH lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    publish = 1'b0;
    case (state_q)
      StIdle: begin
        if (commit_ok) state_d = StFilling;
      end
      StFilling: begin
        if (&captured_q) state_d = StPublish;
      end
      StPublish: begin
        publish = 1'b1;
        state_d = commit_ok ? StFilling : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state, frame capture registers and published outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      captured_q    <= '0;
      shadow_q      <= '0;
      perr_q        <= '0;
      hex_q         <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      captured_q    <= captured_d;
      shadow_q      <= shadow_d;
      perr_q        <= perr_d;
      frame_valid_q <= publish;
      if (publish) hex_q <= shadow_q;
    end
  end

`ifdef SEGMENT_DECODER_DP_EN
  logic [DIGITS-1:0] dp_shadow_q, dp_shadow_d, dp_q;

  // Decimal-point shadow tracks the nibble shadow slot for slot (dp is active-low in).
  always_comb begin
    dp_shadow_d = dp_shadow_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (commit_ok && digit_sel[i]) dp_shadow_d[i] = ~seg_in[7];
    end
  end

  // Decimal-point shadow and published copy.
  always_ff @(posedge clock) begin
    if (reset) begin
      dp_shadow_q <= '0;
      dp_q        <= '0;
    end else begin
      dp_shadow_q <= dp_shadow_d;
      if (publish) dp_q <= dp_shadow_q;
    end
  end

  assign dp_out = dp_q;
`else
  assign dp_out = '0;
`endif

  assign hex_out       = hex_q;
  assign frame_valid   = frame_valid_q;
  assign pattern_error = perr_q;
  assign sel_error     = sel_error_q;

endmodule

// File: tb/tb_segment_frame_decoder.sv
// Bench for segment_frame_decoder: directed vector table, two multi-cycle
// sequences (alternating digit, mid-frame reset) and a randomized run checked
// against a behavioural frame model. Honours SEGMENT_DECODER_DP_EN.
module tb_segment_frame_decoder;

  localparam int unsigned Digits = 6;
  localparam int unsigned Stable = 4;
`ifdef SEGMENT_DECODER_DP_EN
  localparam bit DpEn = 1'b1;
`else
  localparam bit DpEn = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic [7:0]        seg_in;
  logic [Digits-1:0] digit_sel;
  logic              seg_valid;
  logic [4*Digits-1:0] hex_out;
  logic [Digits-1:0] dp_out;
  logic              frame_valid;
  logic [Digits-1:0] pattern_error;
  logic              sel_error;

  int tests = 0;
  int fails = 0;
  int fv_seen = 0;

  segment_frame_decoder #(
    .DIGITS        (Digits),
    .STABLE_CYCLES (Stable)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .seg_in        (seg_in),
    .digit_sel     (digit_sel),
    .seg_valid     (seg_valid),
    .hex_out       (hex_out),
    .dp_out        (dp_out),
    .frame_valid   (frame_valid),
    .pattern_error (pattern_error),
    .sel_error     (sel_error)
  );

  always #5 clock = ~clock;

  // Independent copy of the decode table.
  logic [6:0] pats [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  function automatic int lookup(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (pats[i] == p) return i;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
    if (frame_valid === 1'b1) fv_seen++;
  endtask

  task automatic drive(input logic v, input logic [7:0] s, input logic [Digits-1:0] sel,
                       input int n);
    seg_valid = v;
    seg_in    = s;
    digit_sel = sel;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string name, input logic [23:0] hex, input logic [5:0] dp,
                       input logic fv, input logic [5:0] perr, input logic se);
    tests++;
    if (hex_out !== hex || dp_out !== dp || frame_valid !== fv || pattern_error !== perr ||
        sel_error !== se) begin
      fails++;
      $display("FAIL %s: got hex=%h dp=%b fv=%b perr=%b sel_err=%b, want hex=%h dp=%b fv=%b perr=%b sel_err=%b",
               name, hex_out, dp_out, frame_valid, pattern_error, sel_error,
               hex, dp, fv, perr, se);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic reset_dut();
    reset     = 1'b1;
    seg_valid = 1'b0;
    seg_in    = 8'hFF;
    digit_sel = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic        valid;
    logic [7:0]  seg;
    logic [5:0]  sel;
    int          cycles;
    logic [23:0] hex;
    logic [5:0]  dp;
    logic        fv;
    logic [5:0]  perr;
    logic        selerr;
  } vec_t;

  vec_t vecs [18];

  // Behavioural model state for the random run.
  logic [7:0]  m_prev_seg;
  logic [5:0]  m_prev_sel;
  bit          m_have;
  int          m_run;
  logic [3:0]  m_shadow [Digits];
  logic        m_shdp [Digits];
  logic [5:0]  m_cap, m_perr, m_dp;
  logic [23:0] m_hex;
  logic        m_fv, m_selerr;
  int          m_pend;

  task automatic model_reset();
    m_have = 0; m_run = 0; m_cap = '0; m_perr = '0; m_dp = '0; m_hex = '0;
    m_fv = 0; m_selerr = 0; m_pend = 0; m_prev_seg = '0; m_prev_sel = '0;
    for (int d = 0; d < Digits; d++) begin
      m_shadow[d] = '0;
      m_shdp[d]   = 1'b0;
    end
  endtask

  // Predicts outputs after the coming clock edge from the inputs now applied.
  task automatic model_step();
    bit pub, full_before;
    int d, n;
    logic [7:0] s;
    if (reset) begin
      model_reset();
      return;
    end
    pub = (m_pend == 1);
    if (m_pend > 0) m_pend--;
    m_fv = 0;
    m_selerr = 0;
    if (pub) begin
      for (int k = 0; k < Digits; k++) begin
        m_hex[k*4 +: 4] = m_shadow[k];
        m_dp[k]         = m_shdp[k];
      end
      m_fv  = 1;
      m_cap = '0;
    end
    if (seg_valid) begin
      if ($countones(digit_sel) != 1) begin
        m_selerr = 1;
        m_run    = 0;
      end else begin
        s = DpEn ? seg_in : {1'b1, seg_in[6:0]};
        if (m_have && s == m_prev_seg && digit_sel == m_prev_sel) m_run++;
        else begin
          m_run = 1; m_prev_seg = s; m_prev_sel = digit_sel; m_have = 1;
        end
        if (m_run == Stable) begin
          d = 0;
          for (int k = 0; k < Digits; k++) if (digit_sel[k]) d = k;
          n = lookup(seg_in[6:0]);
          if (n < 0) m_perr[d] = 1'b1;
          else begin
            full_before = &m_cap;
            m_shadow[d] = 4'(n);
            m_shdp[d]   = DpEn & ~seg_in[7];
            m_cap[d]    = 1'b1;
            m_perr[d]   = 1'b0;
            if (!full_before && (&m_cap)) m_pend = 2;
          end
        end
      end
    end
  endtask

  initial begin
    logic [5:0] dp0;
    int hold_left;
    logic [7:0] cur_seg;
    logic [5:0] cur_sel;
    dp0 = {5'b0, DpEn};

    vecs[0]  = '{1'b1, 8'h40, 6'b000001, 4, 24'h0,      6'h0, 1'b0, 6'h00, 1'b0};
    vecs[1]  = '{1'b1, 8'hF9, 6'b000010, 4, 24'h0,      6'h0, 1'b0, 6'h00, 1'b0};
    vecs[2]  = '{1'b1, 8'hA4, 6'b000100, 4, 24'h0,      6'h0, 1'b0, 6'h00, 1'b0};
    vecs[3]  = '{1'b1, 8'hB0, 6'b001000, 4, 24'h0,      6'h0, 1'b0, 6'h00, 1'b0};
    vecs[4]  = '{1'b1, 8'h99, 6'b010000, 4, 24'h0,      6'h0, 1'b0, 6'h00, 1'b0};
    vecs[5]  = '{1'b1, 8'h92, 6'b100000, 4, 24'h0,      6'h0, 1'b0, 6'h00, 1'b0};
    vecs[6]  = '{1'b0, 8'hFF, 6'b000000, 1, 24'h0,      6'h0, 1'b0, 6'h00, 1'b0};
    vecs[7]  = '{1'b0, 8'hFF, 6'b000000, 1, 24'h543210, dp0,  1'b1, 6'h00, 1'b0};
    vecs[8]  = '{1'b0, 8'hFF, 6'b000000, 1, 24'h543210, dp0,  1'b0, 6'h00, 1'b0};
    vecs[9]  = '{1'b1, 8'hFF, 6'b000010, 4, 24'h543210, dp0,  1'b0, 6'h02, 1'b0};
    vecs[10] = '{1'b1, 8'hF9, 6'b000010, 4, 24'h543210, dp0,  1'b0, 6'h00, 1'b0};
    vecs[11] = '{1'b1, 8'hFF, 6'b010000, 3, 24'h543210, dp0,  1'b0, 6'h00, 1'b0};
    vecs[12] = '{1'b1, 8'hFF, 6'b000011, 1, 24'h543210, dp0,  1'b0, 6'h00, 1'b1};
    vecs[13] = '{1'b1, 8'hFF, 6'b010000, 3, 24'h543210, dp0,  1'b0, 6'h00, 1'b0};
    vecs[14] = '{1'b1, 8'hFF, 6'b010000, 1, 24'h543210, dp0,  1'b0, 6'h10, 1'b0};
    vecs[15] = '{1'b0, 8'hFF, 6'b000000, 1, 24'h543210, dp0,  1'b0, 6'h10, 1'b0};
    vecs[16] = '{1'b1, 8'hFF, 6'b000000, 1, 24'h543210, dp0,  1'b0, 6'h10, 1'b1};
    vecs[17] = '{1'b0, 8'hFF, 6'b000000, 1, 24'h543210, dp0,  1'b0, 6'h10, 1'b0};

    reset_dut();
    check("reset state", 24'h0, 6'h0, 1'b0, 6'h0, 1'b0);

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].valid, vecs[i].seg, vecs[i].sel, vecs[i].cycles);
      check($sformatf("vec %0d", i), vecs[i].hex, vecs[i].dp, vecs[i].fv, vecs[i].perr,
            vecs[i].selerr);
    end

    // Alternating digit 2 never settles, then a clean hold completes the frame.
    reset_dut();
    drive(1'b1, 8'h88, 6'b000001, 4);
    drive(1'b1, 8'h83, 6'b000010, 4);
    drive(1'b1, 8'hC6, 6'b001000, 4);
    drive(1'b1, 8'hA1, 6'b010000, 4);
    drive(1'b1, 8'h86, 6'b100000, 4);
    fv_seen = 0;
    for (int i = 0; i < 10; i++) drive(1'b1, (i % 2 == 0) ? 8'hB0 : 8'hA4, 6'b000100, 1);
    drive(1'b0, 8'hFF, 6'b000000, 3);
    check_int("alternating no frame", fv_seen, 0);
    drive(1'b1, 8'hB0, 6'b000100, 4);
    drive(1'b0, 8'hFF, 6'b000000, 1);
    check("latency minus one", 24'h0, 6'h0, 1'b0, 6'h0, 1'b0);
    drive(1'b0, 8'hFF, 6'b000000, 1);
    check("alternating frame", 24'hEDC3BA, 6'h0, 1'b1, 6'h0, 1'b0);

    // Reset after three digits discards them; next full frame carries only new values.
    reset_dut();
    drive(1'b1, 8'hF8, 6'b000001, 4);
    drive(1'b1, 8'h80, 6'b000010, 4);
    drive(1'b1, 8'h90, 6'b000100, 4);
    reset_dut();
    check("mid-frame reset", 24'h0, 6'h0, 1'b0, 6'h0, 1'b0);
    fv_seen = 0;
    drive(1'b1, 8'h8E, 6'b000001, 4);
    drive(1'b1, 8'h82, 6'b000010, 4);
    drive(1'b1, 8'h92, 6'b000100, 4);
    drive(1'b1, 8'h99, 6'b001000, 4);
    drive(1'b1, 8'hB0, 6'b010000, 4);
    drive(1'b1, 8'hA4, 6'b100000, 4);
    drive(1'b0, 8'hFF, 6'b000000, 2);
    check("post-reset frame", 24'h23456F, 6'h0, 1'b1, 6'h0, 1'b0);
    drive(1'b0, 8'hFF, 6'b000000, 2);
    check_int("post-reset frame count", fv_seen, 1);

    // Randomized run against the behavioural model.
    reset_dut();
    model_reset();
    hold_left = 0;
    cur_seg = 8'hFF;
    cur_sel = '0;
    for (int c = 0; c < 4000; c++) begin
      if (hold_left == 0) begin
        cur_sel = 6'(1 << $urandom_range(0, Digits - 1));
        if ($urandom_range(0, 99) < 6) cur_sel = 6'($urandom);
        if ($urandom_range(0, 99) < 88) cur_seg = {1'($urandom), pats[$urandom_range(0, 15)]};
        else cur_seg = 8'($urandom);
        hold_left = $urandom_range(1, 6);
      end
      hold_left--;
      reset     = ($urandom_range(0, 599) == 0);
      seg_valid = ($urandom_range(0, 9) != 0);
      seg_in    = cur_seg;
      digit_sel = cur_sel;
      model_step();
      tick();
      check($sformatf("random cycle %0d", c), m_hex, m_dp, m_fv, m_perr, m_selerr);
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
